adder_arbiter: RTL and testbench

//   Shares one WIDTH-bit adder between NUM_REQ requesters (PC/branch-target/address units).

---
 rtl/adder_arbiter.sv | 167 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   One WIDTH-bit adder shared round-robin between NUM_REQ requesters.
//   The result is registered behind a valid/ready handshake. A requester
//   that raises lock_i with its request keeps ownership after the grant.
//   Its following adds take the previous carry out as carry in, so a
//   multi-word add can be built from back-to-back WIDTH-bit adds.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   req_i    : per-requester request; operands are held until granted
//   lock_i   : with req_i, keep ownership and chain the carry into the next op
//   a_i, b_i : operands; requester k uses bits [k*WIDTH +: WIDTH]
//   gnt_o    : one-hot combinational grant; the operands are consumed this cycle
//   sum_o    : registered (a+b+cin) mod 2^WIDTH
//   cout_o   : registered carry out
//   id_o     : index of the requester that owns sum_o
//   valid_o  : sum_o/cout_o/id_o are valid
//   ready_i  : downstream accepts the result when valid_o && ready_i
module adder_arbiter #(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       lock_i,
    input  logic [NUM_REQ*WIDTH-1:0] a_i,
    input  logic [NUM_REQ*WIDTH-1:0] b_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [WIDTH-1:0]         sum_o,
    output logic                     cout_o,
    output logic [IDW-1:0]           id_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic             carry_q, carry_d;

    logic             can_issue;
    logic             issue;
    logic [IDW-1:0]   sel;
    logic             cin;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   sum_full;

    function automatic logic [WIDTH:0] add_cin(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Round-robin successor. NUM_REQ need not be a power of two, so the
    // wrap point is checked explicitly.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] k);
        return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
    endfunction

    assign can_issue = !valid_o || ready_i;
    assign op_a      = a_i[int'(sel)*WIDTH +: WIDTH];
    assign op_b      = b_i[int'(sel)*WIDTH +: WIDTH];
    assign sum_full  = add_cin(op_a, op_b, cin);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            carry_q <= carry_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    ptr_d = next_idx(sel);
                    if (lock_i[sel]) begin
                        owner_d = sel;
                        carry_d = sum_full[WIDTH];
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // Under backpressure nothing moves: the owner and its carry wait.
                if (can_issue) begin
                    if (req_i[owner_q]) begin
                        ptr_d   = next_idx(owner_q);
                        carry_d = sum_full[WIDTH];
                        if (!lock_i[owner_q]) state_d = IDLE;
                    end else begin
                        carry_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: winner search, grant, carry-in selection
    always_comb begin
        logic             found;
        logic [IDW-1:0]   cand;
        found = 1'b0;
        cand  = '0;
        issue = 1'b0;
        sel   = '0;
        cin   = 1'b0;
        case (state_q)
            IDLE: begin
                // Search ptr, ptr+1, ... and wrap, so the last winner goes to the back.
                for (int i = 0; i < NUM_REQ; i++) begin
                    cand = IDW'((int'(ptr_q) + i) % NUM_REQ);
                    if (!found && req_i[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                issue = can_issue && found;
            end
            LOCKED: begin
                sel   = owner_q;
                cin   = carry_q;
                issue = can_issue && req_i[owner_q];
            end
            default: ;
        endcase
        gnt_o = (issue && rst_n_i) ? (NUM_REQ'(1) << sel) : '0;
    end

    // Result register: load on issue, hold under backpressure, clear after handshake
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_o   <= '0;
            cout_o  <= 1'b0;
            id_o    <= '0;
            valid_o <= 1'b0;
        end else if (issue) begin
            sum_o   <= sum_full[WIDTH-1:0];
            cout_o  <= sum_full[WIDTH];
            id_o    <= sel;
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
//   Directed bench for adder_arbiter (WIDTH=32, NUM_REQ=4). Inputs change
//   1 time unit after a rising edge. Checks are made 1 time unit later.
module tb_adder_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    logic                     clk_i;
    logic                     rst_n_i;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ-1:0]       lock_i;
    logic [NUM_REQ*WIDTH-1:0] a_i;
    logic [NUM_REQ*WIDTH-1:0] b_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [WIDTH-1:0]         sum_o;
    logic                     cout_o;
    logic [IDW-1:0]           id_o;
    logic                     valid_o;
    logic                     ready_i;

    int n_cmp = 0;
    int n_err = 0;

    adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req_i   (req_i),
        .lock_i  (lock_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .gnt_o   (gnt_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .id_o    (id_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
        a_i[k*WIDTH +: WIDTH] = a;
        b_i[k*WIDTH +: WIDTH] = b;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] s, input logic c,
                           input logic [1:0] id);
        chk({tag, ".sum"},   sum_o,   s);
        chk({tag, ".cout"},  cout_o,  c);
        chk({tag, ".id"},    id_o,    id);
        chk({tag, ".valid"}, valid_o, 1'b1);
    endtask

    initial begin
        rst_n_i = 1'b0;
        req_i   = 4'b1111;
        lock_i  = '0;
        ready_i = 1'b1;
        a_i     = '0;
        b_i     = '0;
        for (int k = 0; k < NUM_REQ; k++) set_op(k, k, 10);
        #2;
        chk("rst.gnt",   gnt_o,   4'b0000);
        chk("rst.sum",   sum_o,   32'h0);
        chk("rst.cout",  cout_o,  1'b0);
        chk("rst.id",    id_o,    2'd0);
        chk("rst.valid", valid_o, 1'b0);

        // Round robin over all four requesters at full throughput
        tick;
        rst_n_i = 1'b1;
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            chk($sformatf("rr.gnt%0d", k), gnt_o, 4'b0001 << k);
            tick;
            if (k == 3) req_i = 4'b0000;
            #1;
            chk_res($sformatf("rr.res%0d", k), 32'(10 + k), 1'b0, 2'(k));
        end
        chk("rr.gnt_idle", gnt_o, 4'b0000);
        tick;
        chk("rr.valid_clr", valid_o, 1'b0);

        // Backpressure: result held, no grant until ready_i returns
        ready_i = 1'b0;
        req_i   = 4'b0010;
        set_op(1, 5, 6);
        #1;
        chk("bp.gnt_first", gnt_o, 4'b0010);
        tick;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp.gnt_hold%0d", c), gnt_o, 4'b0000);
            chk($sformatf("bp.sum_hold%0d", c), sum_o, 32'd11);
            chk($sformatf("bp.vld_hold%0d", c), valid_o, 1'b1);
            tick;
        end
        ready_i = 1'b1;
        #1;
        chk("bp.gnt_release", gnt_o, 4'b0010);
        tick;
        req_i = 4'b0000;
        #1;
        chk_res("bp.res", 32'd11, 1'b0, 2'd1);

        // Unlocked ops never reuse carry (ptr=2, so req0 wins after wrap)
        req_i = 4'b0001;
        set_op(0, 32'h8000_0000, 32'h8000_0000);
        #1;
        chk("nl.gnt0", gnt_o, 4'b0001);
        tick;
        set_op(0, 32'h1, 32'h1);
        #1;
        chk_res("nl.res0", 32'h0, 1'b1, 2'd0);
        chk("nl.gnt1", gnt_o, 4'b0001);
        tick;
        req_i = 4'b0000;
        #1;
        chk_res("nl.res1", 32'h2, 1'b0, 2'd0);

        // Locked chain on req1 (ptr=1); req2 waits for the release
        req_i  = 4'b0110;
        lock_i = 4'b0010;
        set_op(1, 32'hFFFF_FFFF, 32'h1);
        set_op(2, 32'd7, 32'd8);
        #1;
        chk("ch.gnt0", gnt_o, 4'b0010);
        tick;
        lock_i = 4'b0000;
        set_op(1, 32'h0, 32'h0);
        #1;
        chk_res("ch.res0", 32'h0, 1'b1, 2'd1);
        chk("ch.gnt1", gnt_o, 4'b0010);
        tick;
        req_i = 4'b0100;
        #1;
        chk_res("ch.res1", 32'h1, 1'b0, 2'd1);
        chk("ch.gnt2", gnt_o, 4'b0100);
        tick;
        req_i = 4'b0000;
        #1;
        chk_res("ch.res2", 32'd15, 1'b0, 2'd2);

        // Owner 3 locks with carry 1, then drops its request
        req_i  = 4'b1000;
        lock_i = 4'b1000;
        set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_op(0, 32'd4, 32'd5);
        #1;
        chk("dr.gnt0", gnt_o, 4'b1000);
        tick;
        req_i  = 4'b0001;
        lock_i = 4'b0000;
        #1;
        chk_res("dr.res0", 32'hFFFF_FFFE, 1'b1, 2'd3);
        chk("dr.gnt_none", gnt_o, 4'b0000);
        tick;
        chk("dr.valid_clr", valid_o, 1'b0);
        chk("dr.gnt1", gnt_o, 4'b0001);
        tick;
        req_i = 4'b0000;
        #1;
        chk_res("dr.res1", 32'd9, 1'b0, 2'd0);

        // Reset while LOCKED with a valid result (ptr=1, so req2 wins)
        req_i  = 4'b0100;
        lock_i = 4'b0100;
        set_op(2, 32'hFFFF_FFFF, 32'h1);
        #1;
        chk("mr.gnt", gnt_o, 4'b0100);
        tick;
        req_i = 4'b0101;
        #1;
        chk_res("mr.pre", 32'h0, 1'b1, 2'd2);
        rst_n_i = 1'b0;
        #1;
        chk("mr.sum",   sum_o,   32'h0);
        chk("mr.cout",  cout_o,  1'b0);
        chk("mr.id",    id_o,    2'd0);
        chk("mr.valid", valid_o, 1'b0);
        chk("mr.gnt",   gnt_o,   4'b0000);
        tick;
        rst_n_i = 1'b1;
        #1;
        chk("mr.gnt_after", gnt_o, 4'b0001);
        tick;
        req_i = 4'b0000;
        #1;
        chk_res("mr.res_after", 32'd9, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
